// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with run-time divisor load.
// Ports: clk_in/rst, en, sync, wr_en/wr_ch/wr_div, rd_div, div_clk, tick.
module clk_div_multi #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 40000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  output logic [DIV_W-1:0] rd_div,
  output logic [NCH-1:0]   div_clk,
  output logic [NCH-1:0]   tick
);

  localparam int DEF_CL = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;

  logic [DIV_W-1:0] cnt_q  [NCH];
  logic [DIV_W-1:0] cnt_d  [NCH];
  logic [DIV_W-1:0] act_q  [NCH];
  logic [DIV_W-1:0] act_d  [NCH];
  logic [DIV_W-1:0] pend_q [NCH];
  logic [DIV_W-1:0] pend_d [NCH];
  logic [DIV_W-1:0] nxt    [NCH];
  logic [NCH-1:0]   clk_q, clk_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [DIV_W-1:0] rd_q, rd_d;

  // Divisors of 0 and 1 cannot form a two-phase clock; run them as 2.
  function automatic logic [DIV_W-1:0] clamp(
    input logic [DIV_W-1:0] d
  );
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // A write in this cycle overrides the stored pending value so that
      // a coincident wrap or sync loads the newly written divisor.
      nxt[i] = (wr_en && (wr_ch == 4'(i))) ? wr_div : pend_q[i];
      pend_d[i] = nxt[i];
      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      if (sync) begin
        cnt_d[i] = '0;
        act_d[i] = clamp(nxt[i]);
        if (en[i]) clk_d[i] = 1'b1;
      end else if (en[i]) begin
        if (cnt_q[i] == act_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          act_d[i] = clamp(nxt[i]);
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        // Outputs are registered from the next count so they line up
        // with the count value they describe.
        clk_d[i]  = cnt_d[i] < (act_d[i] >> 1);
        tick_d[i] = cnt_d[i] == act_d[i] - DIV_W'(1);
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ch == 4'(i)) rd_d = act_q[i];
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= DIV_W'(DEF_CL);
        pend_q[i] <= DIV_W'(DEFAULT_DIV);
      end
      clk_q  <= '0;
      tick_q <= '0;
      rd_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      rd_q   <= rd_d;
    end
  end

  assign div_clk = clk_q;
  assign tick    = tick_q;
  assign rd_div  = rd_q;

endmodule
